pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central sequencer for the 8-bit-PC, 16-bit-instruction pipelined CPU. Decides each cycle whether the PC advances, loads a branch target, or holds. Controls the enables and NOP-bubble/flush of the IF/ID and ID/EX stage registers, resolving taken branches (BZ/BN/JUMP) and RAW hazards. Also runs the IDLE/RUN/HALT machine and keeps stall/flush performance counters.

## Interface

- CNT_W, 16, width of the stall and flush performance counters
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run permission; low freezes the pipeline
- start  in  1  level; with enable, leaves IDLE
- id_ir  in  16  instruction in ID stage
- ex_ir  in  16  instruction in EX stage
- mem_ir  in  16  instruction in MEM stage
- zf, nf  in  1 each  zero/negative flags produced by EX for ex_ir
- state  out  2  00 IDLE, 01 RUN, 10 HALT
- pc_en  out  1  PC register write enable
- pc_sel  out  1  1 = PC loads branch target (reg_C[7:0]), 0 = PC+1
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_bubble  out  1  ID/EX loads NOP
- pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB registers
- stall_cnt  out  CNT_W  cycles stalled on hazard, saturating
- flush_cnt  out  CNT_W  taken branches, saturating

## Operation

- Field layout: op=[15:11], rd=[10:8], ra=[6:4], rb=[2:0].
- Opcodes: NOP 00000, HALT 00001, LOAD 00010, STORE 00011, ADD 01000, ADDI 01001, SUB 01010, CMP 01100, JUMP 11000, BZ 11010, BN 11100.
- Writes rd: LOAD, ADD, ADDI, SUB.
- Reads ra/rb: ADD, SUB, CMP.
- Reads ra: LOAD, STORE.
- Reads rd: ADDI, STORE, BZ, BN, JUMP.
- State IDLE: all enables 0; goes to RUN when start & enable.
- State RUN, checked in priority order:
  - enable=0: go to IDLE and freeze.
  - ex_ir op=HALT: go to HALT.
  - Otherwise stay in RUN.
- State HALT: sticky. Enables 0. Exits to IDLE only when enable=0, or on reset.
- In RUN with enable=1, the controls have this priority:
  1. Taken branch: ex_ir is JUMP, BZ with zf=1, or BN with nf=1.
     - Asserts pc_en=1, pc_sel=1, ifid_flush=1, idex_bubble=1, pipe_en=1.
     - flush_cnt increments.
     - A hazard in the same cycle is ignored, because the ID instruction is squashed.
  2. RAW hazard: a source register of id_ir equals rd of an ex_ir or mem_ir that writes rd.
     - Asserts pc_en=0, ifid_en=0, idex_bubble=1, pipe_en=1.
     - stall_cnt increments.
     - WB needs no check, because the register file is write-before-read.
  3. Normal: pc_en=1, pc_sel=0, ifid_en=1, pipe_en=1, flush/bubble=0.
- A HALT in EX forces pc_en=0. The older instructions in MEM/WB still retire in that cycle (pipe_en=1), then the machine freezes.
- Counters saturate at all-ones. They are cleared only by reset.

## Timing

- state and the counters are registered.
- All other outputs are combinational from state and the current ir/flag inputs, valid in the same cycle.
- Reset values:
  - state=IDLE.
  - stall_cnt=flush_cnt=0.
  - Outputs derived from IDLE: pc_en=pc_sel=ifid_en=ifid_flush=idex_bubble=pipe_en=0.
- IDLE to RUN: start&enable sampled at edge N; state=RUN from N; first pc_en=1 in cycle N+1.
- Branch penalty: exactly 2 bubbles, the wrong-path IF/ID and ID/EX instructions.
- Hazard stall lasts until the producer leaves MEM: at most 2 cycles for a producer in EX.
- Reset asserted mid-operation: state and counters clear immediately, asynchronously. Outputs go to 0 without waiting for a clock.

## Structure

- Shared package: the opcode constants, the field-slice indices, the state encodings, and the writes_rd/reads_* decode functions. The register file and decoder reuse the same package.
- One sub-module, hazard_detect: combinational; inputs id_ir, ex_ir, mem_ir; output stall_req.
- Counters and the FSM live in pipe_ctrl.

## Test plan

- Reset then start=1, enable=1, all irs NOP:
  - state=RUN after 1 edge.
  - Then pc_en=1, pc_sel=0, ifid_en=1 every cycle.
  - stall_cnt=flush_cnt=0.
- ex_ir=BZ (16'hD000), zf=1:
  - pc_sel=1, ifid_flush=1, idex_bubble=1.
  - flush_cnt 0→1.
  - Same ex_ir with zf=0 gives normal advance.
- ex_ir=ADD r1 (16'h4100), id_ir=ADD r2,r1,r3 (16'h4213):
  - pc_en=0, ifid_en=0, idex_bubble=1.
  - stall_cnt increments.
  - When the ADD moves to mem_ir, the stall holds one more cycle, then releases.
- Taken BN (ex_ir=16'hE000, nf=1) together with a hazard in id_ir: branch response only, stall_cnt unchanged.
- ex_ir=HALT (16'h0800):
  - state=HALT next edge, with all enables 0 thereafter.
  - enable=0 returns the machine to IDLE.
- Mid-RUN reset pulse: state=IDLE, counters 0, pc_en=0 asynchronously.
- stall_cnt preloaded to near all-ones by long stalls with CNT_W=4: saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared ISA definitions for the 8-bit-PC / 16-bit-instruction CPU:
// opcodes, instruction field positions, sequencer states and operand-usage decode.
package pipe_ctrl_pkg;

    localparam int IR_W  = 16;
    localparam int OP_W  = 5;
    localparam int REG_W = 3;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 11;
    localparam int RD_MSB = 10;
    localparam int RD_LSB = 8;
    localparam int RA_MSB = 6;
    localparam int RA_LSB = 4;
    localparam int RB_MSB = 2;
    localparam int RB_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 5'b00000,
        OP_HALT  = 5'b00001,
        OP_LOAD  = 5'b00010,
        OP_STORE = 5'b00011,
        OP_ADD   = 5'b01000,
        OP_ADDI  = 5'b01001,
        OP_SUB   = 5'b01010,
        OP_CMP   = 5'b01100,
        OP_JUMP  = 5'b11000,
        OP_BZ    = 5'b11010,
        OP_BN    = 5'b11100
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    function automatic logic [OP_W-1:0] ir_op(input logic [IR_W-1:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [REG_W-1:0] ir_rd(input logic [IR_W-1:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [REG_W-1:0] ir_ra(input logic [IR_W-1:0] ir);
        return ir[RA_MSB:RA_LSB];
    endfunction

    function automatic logic [REG_W-1:0] ir_rb(input logic [IR_W-1:0] ir);
        return ir[RB_MSB:RB_LSB];
    endfunction

    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB);
    endfunction

    function automatic logic reads_ra(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) ||
               (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic reads_rb(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    function automatic logic reads_rd(input logic [OP_W-1:0] op);
        return (op == OP_ADDI) || (op == OP_STORE) || (op == OP_BZ) ||
               (op == OP_BN) || (op == OP_JUMP);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// RAW hazard detector: flags when any register read by the ID instruction is
// the destination of an older EX or MEM instruction. WB is not checked because
// the register file writes before it reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [IR_W-1:0] id_ir,
    input  logic [IR_W-1:0] ex_ir,
    input  logic [IR_W-1:0] mem_ir,
    output logic            stall_req
);

    logic [OP_W-1:0]  id_op;
    logic             ex_wr;
    logic             mem_wr;
    logic [REG_W-1:0] ex_rd;
    logic [REG_W-1:0] mem_rd;

    // Source slots of the ID instruction: 0 = ra, 1 = rb, 2 = rd
    logic [2:0]            src_used;
    logic [REG_W-1:0]      src_reg [3];
    logic [2:0]            src_hit;

    // Instruction bits that never name a register are not looked at here
    logic unused_fields;

    assign id_op  = ir_op(id_ir);
    assign ex_wr  = writes_rd(ir_op(ex_ir));
    assign mem_wr = writes_rd(ir_op(mem_ir));
    assign ex_rd  = ir_rd(ex_ir);
    assign mem_rd = ir_rd(mem_ir);

    assign src_used   = {reads_rd(id_op), reads_rb(id_op), reads_ra(id_op)};
    assign src_reg[0] = ir_ra(id_ir);
    assign src_reg[1] = ir_rb(id_ir);
    assign src_reg[2] = ir_rd(id_ir);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] &&
                                 ((ex_wr  && (src_reg[gi] == ex_rd)) ||
                                  (mem_wr && (src_reg[gi] == mem_rd)));
        end
    endgenerate

    assign stall_req = |src_hit;

    assign unused_fields = ^{id_ir[7], id_ir[3], ex_ir[7:0], mem_ir[7:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: IDLE/RUN/HALT machine, PC and stage-register steering
// for taken branches and RAW stalls, plus saturating stall/flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [IR_W-1:0]  id_ir,
    input  logic [IR_W-1:0]  ex_ir,
    input  logic [IR_W-1:0]  mem_ir,
    input  logic             zf,
    input  logic             nf,
    output logic [1:0]       state,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t           state_reg;
    logic [OP_W-1:0]  ex_op;
    logic             stall_req;
    logic             run_active;
    logic             ex_halt;
    logic             branch_taken;
    logic             do_flush;
    logic             do_stall;

    // Index 0 counts hazard stalls, index 1 counts taken branches
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    hazard_detect u_hazard (
        .id_ir     (id_ir),
        .ex_ir     (ex_ir),
        .mem_ir    (mem_ir),
        .stall_req (stall_req)
    );

    assign ex_op        = ir_op(ex_ir);
    assign run_active   = (state_reg == ST_RUN) && enable;
    assign ex_halt      = (ex_op == OP_HALT);
    assign branch_taken = (ex_op == OP_JUMP) ||
                          ((ex_op == OP_BZ) && zf) ||
                          ((ex_op == OP_BN) && nf);

    // A taken branch squashes the ID instruction, so its hazard is moot
    assign do_flush = run_active && branch_taken;
    assign do_stall = run_active && !branch_taken && !ex_halt && stall_req;
    assign cnt_inc  = {do_flush, do_stall};

    // Run-state machine; HALT is left only by dropping enable
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (start && enable) state_reg <= ST_RUN;
                ST_RUN: begin
                    if (!enable)      state_reg <= ST_IDLE;
                    else if (ex_halt) state_reg <= ST_HALT;
                end
                ST_HALT: if (!enable) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            // Saturating performance counter, cleared only by reset
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Same-cycle pipeline steering: branch > halt drain > hazard stall > advance
    always_comb begin
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b0;
        if (run_active) begin
            if (branch_taken) begin
                pc_en       = 1'b1;
                pc_sel      = 1'b1;
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                pipe_en     = 1'b1;
            end else if (ex_halt) begin
                // Let MEM/WB retire; nothing younger follows the HALT
                idex_bubble = 1'b1;
                pipe_en     = 1'b1;
            end else if (stall_req) begin
                idex_bubble = 1'b1;
                pipe_en     = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                pipe_en = 1'b1;
            end
        end
    end

    assign state     = state_reg;
    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: each row drives one cycle of inputs, pushes the
// expected observation to a scoreboard and pops/compares it mid-cycle.
module tb_pipe_ctrl;

    localparam int CNT_W = 4;

    // Observation word: {state[1:0], ctl[5:0], stall_cnt[3:0], flush_cnt[3:0]}
    // ctl = {pc_en, pc_sel, ifid_en, ifid_flush, idex_bubble, pipe_en}
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;

    localparam logic [5:0] C_OFF   = 6'b000000;
    localparam logic [5:0] C_RUN   = 6'b101001;
    localparam logic [5:0] C_BR    = 6'b111111;
    localparam logic [5:0] C_STALL = 6'b000011;
    localparam logic [5:0] C_HALT  = 6'b000001;

    localparam logic [15:0] M_ALL   = 16'hFFFF;
    localparam logic [15:0] M_BR    = 16'hF7FF;  // ifid_en not pinned during a flush
    localparam logic [15:0] M_STALL = 16'hEFFF;  // pc_sel irrelevant while pc_en=0
    localparam logic [15:0] M_HALT  = 16'hE1FF;  // only pc_en/pipe_en pinned

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             start = 1'b0;
    logic [15:0]      id_ir = '0;
    logic [15:0]      ex_ir = '0;
    logic [15:0]      mem_ir = '0;
    logic             zf = 1'b0;
    logic             nf = 1'b0;
    logic [1:0]       state;
    logic             pc_en, pc_sel, ifid_en, ifid_flush, idex_bubble, pipe_en;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [15:0]      obs;

    always #5 clock = ~clock;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .id_ir       (id_ir),
        .ex_ir       (ex_ir),
        .mem_ir      (mem_ir),
        .zf          (zf),
        .nf          (nf),
        .state       (state),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .pipe_en     (pipe_en),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    assign obs = {state, pc_en, pc_sel, ifid_en, ifid_flush, idex_bubble, pipe_en,
                  stall_cnt, flush_cnt};

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] ex;
        logic [15:0] mem;
        logic        zf;
        logic        nf;
        logic        en;
        logic        st;
        logic [15:0] vec;
        logic [15:0] mask;
    } stim_t;

    typedef struct {
        string       name;
        logic [15:0] vec;
        logic [15:0] mask;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] mk(logic [1:0] st, logic [5:0] c, int s, int f);
        return {st, c, CNT_W'(s), CNT_W'(f)};
    endfunction

    function automatic stim_t row(logic [15:0] id, logic [15:0] ex, logic [15:0] mem,
                                  logic z, logic n, logic en, logic st,
                                  logic [15:0] vec, logic [15:0] mask);
        stim_t r;
        r = '{id, ex, mem, z, n, en, st, vec, mask};
        return r;
    endfunction

    task automatic drive_push(input stim_t s, input string name);
        id_ir  = s.id;
        ex_ir  = s.ex;
        mem_ir = s.mem;
        zf     = s.zf;
        nf     = s.nf;
        enable = s.en;
        start  = s.st;
        exp_q.push_back('{name, s.vec, s.mask});
    endtask

    task automatic test_reset();
        stim_t t[4];
        t[0] = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 1, mk(S_IDLE, C_OFF, 0, 0), M_ALL);
        t[1] = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 0, mk(S_IDLE, C_OFF, 0, 0), M_ALL);
        t[2] = row(16'h0, 16'h0, 16'h0, 0, 0, 0, 1, mk(S_IDLE, C_OFF, 0, 0), M_ALL);
        t[3] = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 0, mk(S_IDLE, C_OFF, 0, 0), M_ALL);
        repeat (2) @(posedge clock);
        #1;
        foreach (t[i]) begin
            drive_push(t[i], $sformatf("reset[%0d]", i));
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.vec);
            end else $display("ok   %s: %h", e.name, obs);
            @(posedge clock);
            #1;
            if (i == 0) reset = 1'b1;
        end
    endtask

    task automatic test_start();
        stim_t t[4];
        t[0] = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 1, mk(S_IDLE, C_OFF, 0, 0), M_ALL);
        t[1] = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 1, mk(S_RUN,  C_RUN, 0, 0), M_ALL);
        t[2] = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 0, mk(S_RUN,  C_RUN, 0, 0), M_ALL);
        t[3] = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 0, mk(S_RUN,  C_RUN, 0, 0), M_ALL);
        foreach (t[i]) begin
            drive_push(t[i], $sformatf("start[%0d]", i));
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.vec);
            end else $display("ok   %s: %h", e.name, obs);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_branch();
        stim_t t[7];
        t[0] = row(16'h0, 16'hD000, 16'h0, 1, 0, 1, 0, mk(S_RUN, C_BR,  0, 0), M_BR);
        t[1] = row(16'h0, 16'h0000, 16'h0, 0, 0, 1, 0, mk(S_RUN, C_RUN, 0, 1), M_ALL);
        t[2] = row(16'h0, 16'hD000, 16'h0, 0, 0, 1, 0, mk(S_RUN, C_RUN, 0, 1), M_ALL);
        t[3] = row(16'h0, 16'hC000, 16'h0, 0, 0, 1, 0, mk(S_RUN, C_BR,  0, 1), M_BR);
        t[4] = row(16'h0, 16'hE000, 16'h0, 1, 0, 1, 0, mk(S_RUN, C_RUN, 0, 2), M_ALL);
        t[5] = row(16'h0, 16'hD000, 16'h0, 0, 1, 1, 0, mk(S_RUN, C_RUN, 0, 2), M_ALL);
        t[6] = row(16'h0, 16'h0000, 16'h0, 0, 0, 1, 0, mk(S_RUN, C_RUN, 0, 2), M_ALL);
        foreach (t[i]) begin
            drive_push(t[i], $sformatf("branch[%0d]", i));
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.vec);
            end else $display("ok   %s: %h", e.name, obs);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_hazard();
        stim_t t[7];
        t[0] = row(16'h4213, 16'h4100, 16'h0000, 0, 0, 1, 0, mk(S_RUN, C_STALL, 0, 2), M_STALL);
        t[1] = row(16'h4213, 16'h0000, 16'h4100, 0, 0, 1, 0, mk(S_RUN, C_STALL, 1, 2), M_STALL);
        t[2] = row(16'h4213, 16'h0000, 16'h0000, 0, 0, 1, 0, mk(S_RUN, C_RUN,   2, 2), M_ALL);
        t[3] = row(16'h4900, 16'h1100, 16'h0000, 0, 0, 1, 0, mk(S_RUN, C_STALL, 2, 2), M_STALL);
        t[4] = row(16'h4900, 16'h6100, 16'h0000, 0, 0, 1, 0, mk(S_RUN, C_RUN,   3, 2), M_ALL);
        t[5] = row(16'h1930, 16'h0000, 16'h4300, 0, 0, 1, 0, mk(S_RUN, C_STALL, 3, 2), M_STALL);
        t[6] = row(16'h0000, 16'h4100, 16'h0000, 0, 0, 1, 0, mk(S_RUN, C_RUN,   4, 2), M_ALL);
        foreach (t[i]) begin
            drive_push(t[i], $sformatf("hazard[%0d]", i));
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.vec);
            end else $display("ok   %s: %h", e.name, obs);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_branch_hazard();
        stim_t t[2];
        t[0] = row(16'h4213, 16'hE000, 16'h4100, 0, 1, 1, 0, mk(S_RUN, C_BR,  4, 2), M_BR);
        t[1] = row(16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, mk(S_RUN, C_RUN, 4, 3), M_ALL);
        foreach (t[i]) begin
            drive_push(t[i], $sformatf("branch_hazard[%0d]", i));
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.vec);
            end else $display("ok   %s: %h", e.name, obs);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_halt();
        stim_t t[6];
        t[0] = row(16'h0, 16'h0800, 16'h4100, 0, 0, 1, 0, mk(S_RUN,  C_HALT, 4, 3), M_HALT);
        t[1] = row(16'h0, 16'h0000, 16'h0000, 0, 0, 1, 0, mk(S_HALT, C_OFF,  4, 3), M_ALL);
        t[2] = row(16'h0, 16'h0000, 16'h0000, 0, 0, 1, 1, mk(S_HALT, C_OFF,  4, 3), M_ALL);
        t[3] = row(16'h0, 16'h0000, 16'h0000, 0, 0, 0, 0, mk(S_HALT, C_OFF,  4, 3), M_ALL);
        t[4] = row(16'h0, 16'h0000, 16'h0000, 0, 0, 0, 0, mk(S_IDLE, C_OFF,  4, 3), M_ALL);
        t[5] = row(16'h0, 16'h0000, 16'h0000, 0, 0, 1, 0, mk(S_IDLE, C_OFF,  4, 3), M_ALL);
        foreach (t[i]) begin
            drive_push(t[i], $sformatf("halt[%0d]", i));
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.vec);
            end else $display("ok   %s: %h", e.name, obs);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_async_reset();
        stim_t t[2];
        t[0] = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 1, mk(S_IDLE, C_OFF, 4, 3), M_ALL);
        t[1] = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 0, mk(S_RUN,  C_RUN, 4, 3), M_ALL);
        foreach (t[i]) begin
            drive_push(t[i], $sformatf("async_reset[%0d]", i));
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.vec);
            end else $display("ok   %s: %h", e.name, obs);
            @(posedge clock);
            #1;
        end
        // Pulse reset between clock edges; everything must clear without an edge
        drive_push(row(16'h0, 16'h0, 16'h0, 0, 0, 1, 0, mk(S_IDLE, C_OFF, 0, 0), M_ALL),
                   "async_reset[mid]");
        #2 reset = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.mask) !== (e.vec & e.mask)) begin
            errors++;
            $display("FAIL %s: got %h required %h", e.name, obs, e.vec);
        end else $display("ok   %s: %h", e.name, obs);
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_saturation();
        stim_t s;
        for (int k = -1; k <= 18; k++) begin
            if (k < 0)
                s = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 1, mk(S_IDLE, C_OFF, 0, 0), M_ALL);
            else if (k < 18)
                s = row(16'h4213, 16'h4100, 16'h0, 0, 0, 1, 0,
                        mk(S_RUN, C_STALL, (k > 15) ? 15 : k, 0), M_STALL);
            else
                s = row(16'h0, 16'h0, 16'h0, 0, 0, 1, 0, mk(S_RUN, C_RUN, 15, 0), M_ALL);
            drive_push(s, $sformatf("saturation[%0d]", k + 1));
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.vec);
            end else $display("ok   %s: %h", e.name, obs);
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_branch();
        test_hazard();
        test_branch_hazard();
        test_halt();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
